exu_issue_queue: RTL and testbench
==================================

Name: exu_issue_queue

Overview:
In-order issue buffer that sits between decode and the execution unit and acts as the transmitting end of the exu operand/control interface. It buffers decoded instructions in a small FIFO and tracks a 32-entry busy scoreboard for long-latency destinations (loads, mul/div). It presents the head instruction to exu only when the instruction has no RAW or WAW hazard against an outstanding long-latency result.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2
PAYLOAD_W, 256, opaque bits carried to exu: src1/src2/imm, pc, instr, alu/cx/muldiv type, is_word, is_unsigned, is_imm, is_store, ls_size
CNT_W, 16, width of the stall performance counter

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous queue flush
enq_valid  in  1  decode presents an instruction
enq_ready  out  1  queue accepts the instruction
enq_rs1  in  5  source 1 logical register
enq_rs2  in  5  source 2 logical register
enq_rd  in  5  destination logical register
enq_src1_is_reg  in  1  rs1 is actually read
enq_src2_is_reg  in  1  rs2 is actually read
enq_need_to_wb  in  1  instruction writes rd
enq_is_long  in  1  load or mul/div, so the result returns via the wb port
enq_payload  in  PAYLOAD_W  remaining exu fields
deq_valid  out  1  head instruction is issuable
deq_ready  in  1  exu accepts the instruction
deq_rs1, deq_rs2, deq_rd  out  5 each  head fields
deq_src1_is_reg, deq_src2_is_reg, deq_need_to_wb, deq_is_long  out  1 each  head fields
deq_payload  out  PAYLOAD_W  head payload
wb_valid  in  1  long-latency result written back
wb_rd  in  5  destination of that result
count  out  $clog2(DEPTH)+1  occupied entries
stall_cnt  out  CNT_W  cycles the head was blocked by a hazard

Behaviour:
- Storage and pointers
  - Circular FIFO with head/tail pointers that wrap modulo DEPTH.
  - `count` is registered.
  - Payload and fields are stored in registers. Deq fields are driven directly from the head entry and are don't-care when the queue is empty.
- Reset
  - Clears the pointers, `count`=0, all busy bits, and `stall_cnt`=0.
  - While reset is high: `enq_ready`=0 and `deq_valid`=0.
- Enqueue
  - `enq_ready` = !reset & !flush & (`count` != DEPTH).
  - A transfer occurs when enq_valid & enq_ready; the entry is written at tail.
  - No pass-through: when full, `enq_ready`=0 even if a dequeue happens in the same cycle.
  - Minimum latency from enqueue to `deq_valid` is 1 cycle, i.e. an entry enqueued in cycle N can issue in cycle N+1.
- Busy lookup `is_busy(r)`
  - Equals busy[r] & (r != 0) & !(wb_valid & wb_rd == r).
  - This gives same-cycle writeback bypass of the scoreboard.
- Hazard at the head
  - hazard = (src1_is_reg & is_busy(rs1)) | (src2_is_reg & is_busy(rs2)) | (need_to_wb & is_busy(rd)).
  - The `rd` term is the WAW check.
- Issue
  - `deq_valid` = !reset & !flush & (`count` != 0) & !hazard.
  - Issue occurs on deq_valid & deq_ready. Head advances; no reordering.
  - Simultaneous enqueue and issue leaves `count` unchanged.
- Scoreboard
  - On issue with need_to_wb & is_long & rd != 0, set busy[rd] in the next cycle.
  - wb_valid clears busy[wb_rd].
  - If the same register is set and cleared in the same cycle, set wins.
  - busy[0] is always 0, and a wb to x0 is ignored.
  - Short ops never set busy bits; exu forwards their results.
- Flush
  - Pointers reset and `count`=0 next cycle; enqueue and issue are both suppressed in the flush cycle.
  - Busy bits are NOT cleared. Already-issued long ops still write back and clear their own bits.
- `stall_cnt`
  - Increments when !reset & !flush & (`count` != 0) & hazard.
  - Saturates at all-ones and is cleared only by reset.
- Protocol assumptions
  - No wb arrives for a register that is not busy.
  - enq fields are stable only in the handshake cycle.

Test Plan:
- Reset, then enqueue 4 independent ALU ops with deq_ready=1 -> each issues 1 cycle after its enqueue, in order; `count` never exceeds 1; `stall_cnt`=0.
- With deq_ready=0, enqueue 5 ops -> `enq_ready` drops after the 4th and `count`=4; raise deq_ready -> the ops issue in FIFO order and the pointers wrap correctly.
- Issue a load with rd=5, then an add with rs1=5 -> the add is held and `stall_cnt` increments each cycle; send wb_valid with wb_rd=5 -> the add issues in that same cycle.
- Issue a mul with rd=7, then an op writing rd=7 with no source dependence -> WAW stall until wb of rd=7; a load to rd=0 followed by a use of x0 -> no stall.
- Fill 3 entries, then assert flush together with enq_valid -> next cycle `count`=0, the flush-cycle enqueue is dropped, and a busy bit set earlier persists until its wb.
- Issue a load with rd=9 while wb_valid with wb_rd=9 arrives in the same cycle (earlier producer) -> busy[9]=1 afterwards (set wins).

Source files
------------

// File: rtl/exu_issue_queue.sv
// In-order issue buffer between decode and exu with a 32-entry busy scoreboard for long-latency results.
// Latency: an entry enqueued in cycle N can issue in cycle N+1; there is no enqueue-to-issue pass-through.
// Backpressure: enq_ready_o drops when full, on flush or in reset. deq_valid_o is withheld while the head has a RAW/WAW hazard.
// Ports: clock_i/reset_i (sync, active-high)/flush_i; enq_* decode side (valid/ready + fields + payload);
//        deq_* exu side (valid/ready + head fields + payload); wb_valid_i/wb_rd_i long-latency writeback;
//        count_o occupied entries; stall_cnt_o saturating hazard-stall cycle counter.
module exu_issue_queue #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 256,
  parameter int CNT_W     = 16
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   enq_valid_i,
  output logic                   enq_ready_o,
  input  logic [4:0]             enq_rs1_i,
  input  logic [4:0]             enq_rs2_i,
  input  logic [4:0]             enq_rd_i,
  input  logic                   enq_src1_is_reg_i,
  input  logic                   enq_src2_is_reg_i,
  input  logic                   enq_need_to_wb_i,
  input  logic                   enq_is_long_i,
  input  logic [PAYLOAD_W-1:0]   enq_payload_i,
  output logic                   deq_valid_o,
  input  logic                   deq_ready_i,
  output logic [4:0]             deq_rs1_o,
  output logic [4:0]             deq_rs2_o,
  output logic [4:0]             deq_rd_o,
  output logic                   deq_src1_is_reg_o,
  output logic                   deq_src2_is_reg_o,
  output logic                   deq_need_to_wb_o,
  output logic                   deq_is_long_o,
  output logic [PAYLOAD_W-1:0]   deq_payload_o,
  input  logic                   wb_valid_i,
  input  logic [4:0]             wb_rd_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [CNT_W-1:0]       stall_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  // Entry storage (no reset: contents are only observed when count_q != 0)
  logic [4:0]           rs1_q  [DEPTH];
  logic [4:0]           rs2_q  [DEPTH];
  logic [4:0]           rd_q   [DEPTH];
  logic [3:0]           flag_q [DEPTH];  // {src1_is_reg, src2_is_reg, need_to_wb, is_long}
  logic [PAYLOAD_W-1:0] pay_q  [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic hazard, do_enq, do_deq, not_empty;

  // Busy lookup with same-cycle writeback bypass; x0 is never busy.
  function automatic logic is_busy(input logic [31:0] busy, input logic [4:0] r,
                                   input logic wb_v, input logic [4:0] wb_r);
    return busy[r] & (r != 5'd0) & !(wb_v & (wb_r == r));
  endfunction

  assign deq_rs1_o         = rs1_q[head_q];
  assign deq_rs2_o         = rs2_q[head_q];
  assign deq_rd_o          = rd_q[head_q];
  assign deq_src1_is_reg_o = flag_q[head_q][3];
  assign deq_src2_is_reg_o = flag_q[head_q][2];
  assign deq_need_to_wb_o  = flag_q[head_q][1];
  assign deq_is_long_o     = flag_q[head_q][0];
  assign deq_payload_o     = pay_q[head_q];

  // The rd term catches WAW against an outstanding long-latency producer.
  assign hazard = (deq_src1_is_reg_o & is_busy(busy_q, deq_rs1_o, wb_valid_i, wb_rd_i)) |
                  (deq_src2_is_reg_o & is_busy(busy_q, deq_rs2_o, wb_valid_i, wb_rd_i)) |
                  (deq_need_to_wb_o  & is_busy(busy_q, deq_rd_o,  wb_valid_i, wb_rd_i));

  assign not_empty   = (count_q != '0);
  assign enq_ready_o = !reset_i & !flush_i & (count_q != FULL);
  assign deq_valid_o = !reset_i & !flush_i & not_empty & !hazard;
  assign do_enq      = enq_valid_i & enq_ready_o;
  assign do_deq      = deq_valid_o & deq_ready_i;
  assign count_o     = count_q;
  assign stall_cnt_o = stall_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    busy_d  = busy_q;
    stall_d = stall_q;

    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_enq) tail_d = tail_q + 1'b1;
      if (do_deq) head_d = head_q + 1'b1;
      if (do_enq && !do_deq) count_d = count_q + 1'b1;
      if (!do_enq && do_deq) count_d = count_q - 1'b1;
      if (not_empty && hazard && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + 1'b1;
    end

    // Clear first so a same-cycle set on the same register wins.
    if (wb_valid_i) busy_d[wb_rd_i] = 1'b0;
    if (do_deq && deq_need_to_wb_o && deq_is_long_o) busy_d[deq_rd_o] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (do_enq) begin
      rs1_q[tail_q]  <= enq_rs1_i;
      rs2_q[tail_q]  <= enq_rs2_i;
      rd_q[tail_q]   <= enq_rd_i;
      flag_q[tail_q] <= {enq_src1_is_reg_i, enq_src2_is_reg_i, enq_need_to_wb_i, enq_is_long_i};
      pay_q[tail_q]  <= enq_payload_i;
    end
  end

endmodule

// File: tb/tb_exu_issue_queue.sv
// Self-checking bench for exu_issue_queue: scoreboard of enqueued entries popped and compared on issue,
// plus per-scenario checks of handshakes, count, hazards, flush and the stall counter.
// Inputs are driven 1 time unit after posedge; outputs are sampled on negedge.
module tb_exu_issue_queue;

  localparam int PW = 256;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          enq_valid = 1'b0;
  logic          enq_ready;
  logic [4:0]    enq_rs1 = '0, enq_rs2 = '0, enq_rd = '0;
  logic          enq_s1 = 1'b0, enq_s2 = 1'b0, enq_wb = 1'b0, enq_long = 1'b0;
  logic [PW-1:0] enq_payload = '0;
  logic          deq_valid;
  logic          deq_ready = 1'b0;
  logic [4:0]    deq_rs1, deq_rs2, deq_rd;
  logic          deq_s1, deq_s2, deq_wb, deq_long;
  logic [PW-1:0] deq_payload;
  logic          wb_valid = 1'b0;
  logic [4:0]    wb_rd = '0;
  logic [2:0]    count;
  logic [15:0]   stall_cnt;

  typedef struct {
    logic [PW-1:0] payload;
    logic [4:0]    rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   stall_exp = 0;

  always #5 clock = ~clock;

  exu_issue_queue #(.DEPTH(4), .PAYLOAD_W(PW), .CNT_W(16)) dut (
    .clock_i(clock), .reset_i(reset), .flush_i(flush),
    .enq_valid_i(enq_valid), .enq_ready_o(enq_ready),
    .enq_rs1_i(enq_rs1), .enq_rs2_i(enq_rs2), .enq_rd_i(enq_rd),
    .enq_src1_is_reg_i(enq_s1), .enq_src2_is_reg_i(enq_s2),
    .enq_need_to_wb_i(enq_wb), .enq_is_long_i(enq_long), .enq_payload_i(enq_payload),
    .deq_valid_o(deq_valid), .deq_ready_i(deq_ready),
    .deq_rs1_o(deq_rs1), .deq_rs2_o(deq_rs2), .deq_rd_o(deq_rd),
    .deq_src1_is_reg_o(deq_s1), .deq_src2_is_reg_o(deq_s2),
    .deq_need_to_wb_o(deq_wb), .deq_is_long_o(deq_long), .deq_payload_o(deq_payload),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
    .count_o(count), .stall_cnt_o(stall_cnt)
  );

  function automatic logic [PW-1:0] make_payload(input int tag);
    logic [31:0] t;
    t = 32'(tag);
    return {t, ~t, 192'h5a5a};
  endfunction

  // Scoreboard: push on accepted enqueue, pop and compare on issue.
  always @(negedge clock) begin
    exp_t e;
    if (deq_valid && deq_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL issue_unexpected: issued tag %0d, scoreboard empty", deq_payload[PW-1 -: 32]);
      end else begin
        e = exp_q.pop_front();
        if (deq_payload !== e.payload || deq_rd !== e.rd) begin
          n_err++;
          $display("FAIL issue_order: got tag %0d rd %0d, expected tag %0d rd %0d",
                   deq_payload[PW-1 -: 32], deq_rd, e.payload[PW-1 -: 32], e.rd);
        end
      end
    end
    if (enq_valid && enq_ready) begin
      e.payload = enq_payload;
      e.rd      = enq_rd;
      exp_q.push_back(e);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_enq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic s1, input logic s2, input logic wb, input logic lng,
                           input int tag);
    enq_valid   = 1'b1;
    enq_rs1     = rs1;
    enq_rs2     = rs2;
    enq_rd      = rd;
    enq_s1      = s1;
    enq_s2      = s2;
    enq_wb      = wb;
    enq_long    = lng;
    enq_payload = make_payload(tag);
  endtask

  task automatic test_reset();
    step();
    reset = 1'b1;
    drive_enq(1, 2, 3, 1, 1, 1, 0, 99);
    @(negedge clock);
    n_cmp++;
    if (enq_ready !== 1'b0 || deq_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hs: enq_ready=%b deq_valid=%b, required 0/0", enq_ready, deq_valid);
    end
    step();
    reset = 1'b0;
    enq_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (count !== 3'd0 || stall_cnt !== 16'd0 || enq_ready !== 1'b1 || deq_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: count=%0d stall=%0d enq_ready=%b deq_valid=%b, required 0/0/1/0",
               count, stall_cnt, enq_ready, deq_valid);
    end
  endtask

  task automatic test_stream();
    deq_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k < 4) drive_enq(5'(k + 1), 5'(k + 2), 5'(k + 10), 1, 1, 1, 0, 100 + k);
      else enq_valid = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (count !== ((k == 0) ? 3'd0 : 3'd1) || deq_valid !== (k != 0)) begin
        n_err++;
        $display("FAIL stream_cycle%0d: count=%0d deq_valid=%b, required %0d/%b",
                 k, count, deq_valid, (k == 0) ? 0 : 1, k != 0);
      end
    end
    step();
    @(negedge clock);
    n_cmp++;
    if (count !== 3'd0 || stall_cnt !== 16'd0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stream_end: count=%0d stall=%0d pending=%0d, required 0/0/0",
               count, stall_cnt, exp_q.size());
    end
  endtask

  task automatic test_fill_wrap();
    logic [2:0] cnt_tab [6];
    cnt_tab = '{3'd4, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    deq_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      drive_enq(1, 2, 5'(20 + k), 1, 1, 1, 0, 200 + k);
      @(negedge clock);
      n_cmp++;
      if (count !== 3'(k) || enq_ready !== (k < 4)) begin
        n_err++;
        $display("FAIL fill_cycle%0d: count=%0d enq_ready=%b, required %0d/%b",
                 k, count, enq_ready, k, k < 4);
      end
    end
    for (int k = 0; k < 6; k++) begin
      step();
      deq_ready = 1'b1;
      if (k < 2) drive_enq(3, 4, 5'd30, 1, 1, 1, 0, 250);
      else enq_valid = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (count !== cnt_tab[k] || deq_valid !== (cnt_tab[k] != 0)) begin
        n_err++;
        $display("FAIL drain_cycle%0d: count=%0d deq_valid=%b, required %0d/%b",
                 k, count, deq_valid, cnt_tab[k], cnt_tab[k] != 0);
      end
      if (k < 2) begin
        n_cmp++;
        if (enq_ready !== (k == 1)) begin
          n_err++;
          $display("FAIL no_passthru_cycle%0d: enq_ready=%b, required %b", k, enq_ready, k == 1);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_pending: %0d entries never issued, required 0", exp_q.size());
    end
  endtask

  task automatic test_raw();
    deq_ready = 1'b1;
    step();
    drive_enq(1, 2, 5, 1, 1, 1, 1, 300);
    step();
    drive_enq(5, 2, 6, 1, 1, 1, 0, 301);
    @(negedge clock);
    n_cmp++;
    if (deq_valid !== 1'b1) begin
      n_err++;
      $display("FAIL raw_load_issue: deq_valid=%b, required 1", deq_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      enq_valid = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (deq_valid !== 1'b0 || stall_cnt !== 16'(stall_exp)) begin
        n_err++;
        $display("FAIL raw_stall%0d: deq_valid=%b stall=%0d, required 0/%0d", i, deq_valid, stall_cnt, stall_exp);
      end
      stall_exp++;
    end
    step();
    wb_valid = 1'b1;
    wb_rd = 5'd5;
    @(negedge clock);
    n_cmp++;
    if (deq_valid !== 1'b1 || stall_cnt !== 16'(stall_exp)) begin
      n_err++;
      $display("FAIL raw_wb_bypass: deq_valid=%b stall=%0d, required 1/%0d", deq_valid, stall_cnt, stall_exp);
    end
    step();
    wb_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (count !== 3'd0 || stall_cnt !== 16'(stall_exp)) begin
      n_err++;
      $display("FAIL raw_end: count=%0d stall=%0d, required 0/%0d", count, stall_cnt, stall_exp);
    end
  endtask

  task automatic test_waw_x0();
    deq_ready = 1'b1;
    step();
    drive_enq(0, 0, 7, 0, 0, 1, 1, 400);
    step();
    drive_enq(1, 2, 7, 1, 1, 1, 0, 401);
    for (int i = 0; i < 2; i++) begin
      step();
      enq_valid = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (deq_valid !== 1'b0 || stall_cnt !== 16'(stall_exp)) begin
        n_err++;
        $display("FAIL waw_stall%0d: deq_valid=%b stall=%0d, required 0/%0d", i, deq_valid, stall_cnt, stall_exp);
      end
      stall_exp++;
    end
    step();
    wb_valid = 1'b1;
    wb_rd = 5'd7;
    @(negedge clock);
    n_cmp++;
    if (deq_valid !== 1'b1) begin
      n_err++;
      $display("FAIL waw_release: deq_valid=%b, required 1", deq_valid);
    end
    step();
    wb_valid = 1'b0;
    drive_enq(1, 2, 0, 1, 1, 1, 1, 402);
    step();
    drive_enq(0, 2, 8, 1, 0, 1, 0, 403);
    step();
    enq_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (deq_valid !== 1'b1 || stall_cnt !== 16'(stall_exp)) begin
      n_err++;
      $display("FAIL x0_no_stall: deq_valid=%b stall=%0d, required 1/%0d", deq_valid, stall_cnt, stall_exp);
    end
    step();
  endtask

  task automatic test_flush();
    deq_ready = 1'b1;
    step();
    drive_enq(1, 2, 12, 1, 1, 1, 1, 500);
    step();
    enq_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      deq_ready = 1'b0;
      drive_enq(1, 2, 3, 1, 1, 1, 0, 501 + k);
    end
    step();
    flush = 1'b1;
    drive_enq(1, 2, 3, 1, 1, 1, 0, 510);
    @(negedge clock);
    n_cmp++;
    if (count !== 3'd3 || enq_ready !== 1'b0 || deq_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_cycle: count=%0d enq_ready=%b deq_valid=%b, required 3/0/0", count, enq_ready, deq_valid);
    end
    step();
    flush = 1'b0;
    enq_valid = 1'b0;
    exp_q.delete();
    @(negedge clock);
    n_cmp++;
    if (count !== 3'd0 || deq_valid !== 1'b0 || stall_cnt !== 16'(stall_exp)) begin
      n_err++;
      $display("FAIL flush_after: count=%0d deq_valid=%b stall=%0d, required 0/0/%0d",
               count, deq_valid, stall_cnt, stall_exp);
    end
    step();
    deq_ready = 1'b1;
    drive_enq(12, 2, 13, 1, 0, 1, 0, 520);
    step();
    enq_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (deq_valid !== 1'b0 || stall_cnt !== 16'(stall_exp)) begin
      n_err++;
      $display("FAIL flush_busy_kept: deq_valid=%b stall=%0d, required 0/%0d", deq_valid, stall_cnt, stall_exp);
    end
    stall_exp++;
    step();
    wb_valid = 1'b1;
    wb_rd = 5'd12;
    @(negedge clock);
    n_cmp++;
    if (deq_valid !== 1'b1) begin
      n_err++;
      $display("FAIL flush_busy_release: deq_valid=%b, required 1", deq_valid);
    end
    step();
    wb_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (count !== 3'd0 || stall_cnt !== 16'(stall_exp)) begin
      n_err++;
      $display("FAIL flush_end: count=%0d stall=%0d, required 0/%0d", count, stall_cnt, stall_exp);
    end
  endtask

  task automatic test_set_wins();
    deq_ready = 1'b1;
    step();
    drive_enq(1, 2, 9, 1, 1, 1, 1, 600);
    step();
    drive_enq(1, 2, 9, 1, 1, 1, 1, 601);
    step();
    enq_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (deq_valid !== 1'b0) begin
      n_err++;
      $display("FAIL setwin_waw: deq_valid=%b, required 0", deq_valid);
    end
    stall_exp++;
    step();
    wb_valid = 1'b1;
    wb_rd = 5'd9;
    drive_enq(9, 0, 10, 1, 0, 1, 0, 602);
    @(negedge clock);
    n_cmp++;
    if (deq_valid !== 1'b1) begin
      n_err++;
      $display("FAIL setwin_issue: deq_valid=%b, required 1", deq_valid);
    end
    step();
    wb_valid = 1'b0;
    enq_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (deq_valid !== 1'b0 || stall_cnt !== 16'(stall_exp)) begin
      n_err++;
      $display("FAIL setwin_busy9: deq_valid=%b stall=%0d, required 0/%0d", deq_valid, stall_cnt, stall_exp);
    end
    stall_exp++;
    step();
    wb_valid = 1'b1;
    wb_rd = 5'd9;
    @(negedge clock);
    n_cmp++;
    if (deq_valid !== 1'b1) begin
      n_err++;
      $display("FAIL setwin_release: deq_valid=%b, required 1", deq_valid);
    end
    step();
    wb_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (count !== 3'd0 || stall_cnt !== 16'(stall_exp) || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL final_state: count=%0d stall=%0d pending=%0d, required 0/%0d/0",
               count, stall_cnt, exp_q.size(), stall_exp);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill_wrap();
    test_raw();
    test_waw_x0();
    test_flush();
    test_set_wins();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
